// File: rtl/pwm_demod.sv
// Differential PWM demodulator: per-frame high-time measurement, signed sample
// rebuild, and hysteretic rising zero-crossing period measurement.
module pwm_demod #(
  parameter int unsigned N    = 8,
  parameter int unsigned PW   = 13,
  parameter int unsigned HYST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fs_clk,
  input  logic          pwm_pos,
  input  logic          pwm_neg,
  output logic [N:0]    sample_o,
  output logic          sample_valid,
  output logic [PW-1:0] period_o,
  output logic          period_valid,
  output logic          silent_o
);

  localparam int unsigned SW = N + 1;
  localparam logic [N-1:0]            CNT_MAX  = '1;
  localparam logic [PW-1:0]           PCNT_MAX = '1;
  localparam logic [PW-1:0]           PCNT_PRE = PCNT_MAX - PW'(1);
  localparam logic signed [SW-1:0]    HYST_POS = SW'(HYST);
  localparam logic signed [SW-1:0]    HYST_NEG = -HYST_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABOVE = 2'd1,
    BELOW = 2'd2
  } state_t;

  logic [N-1:0]  pos_cnt;
  logic [N-1:0]  neg_cnt;
  logic          primed;
  logic [PW-1:0] pcnt;
  logic          have_ref;
  state_t        state;
  state_t        state_next;
  logic          rising_c;
  logic          silence_c;
  logic          ge_c;
  logic          le_c;

  // High-time counters: reload on the strobe, saturate otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_cnt <= '0;
      neg_cnt <= '0;
      primed  <= 1'b0;
    end else if (fs_clk) begin
      pos_cnt <= N'(pwm_pos);
      neg_cnt <= N'(pwm_neg);
      primed  <= 1'b1;
    end else begin
      if (pwm_pos && (pos_cnt != CNT_MAX)) pos_cnt <= pos_cnt + N'(1);
      if (pwm_neg && (neg_cnt != CNT_MAX)) neg_cnt <= neg_cnt + N'(1);
    end
  end

  // Sample rebuild; the priming strobe only opens the first frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_o     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= fs_clk && primed;
      if (fs_clk && primed) sample_o <= {1'b0, pos_cnt} - {1'b0, neg_cnt};
    end
  end

  assign ge_c = $signed(sample_o) >= HYST_POS;
  assign le_c = $signed(sample_o) <= HYST_NEG;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Crossing decision; silence overrides the hysteresis state
  always_comb begin
    state_next = state;
    rising_c   = 1'b0;
    silence_c  = 1'b0;
    if (sample_valid) begin
      case (state)
        IDLE: begin
          if (le_c)      state_next = BELOW;
          else if (ge_c) state_next = ABOVE;
        end
        ABOVE: begin
          if (le_c) state_next = BELOW;
        end
        BELOW: begin
          if (ge_c) begin
            state_next = ABOVE;
            rising_c   = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (!rising_c && (pcnt == PCNT_PRE)) begin
        silence_c  = 1'b1;
        state_next = IDLE;
      end
    end
  end

  // Period measurement and silence tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt         <= '0;
      have_ref     <= 1'b0;
      period_o     <= '0;
      period_valid <= 1'b0;
      silent_o     <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      if (sample_valid) begin
        if (rising_c) begin
          pcnt         <= '0;
          have_ref     <= 1'b1;
          silent_o     <= 1'b0;
          period_valid <= have_ref;
          if (have_ref) period_o <= pcnt + PW'(1);
        end else begin
          if (pcnt != PCNT_MAX) pcnt <= pcnt + PW'(1);
          if (silence_c) begin
            have_ref <= 1'b0;
            silent_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Scoreboard bench for pwm_demod: stimulus pushes model expectations, a
// monitor pops them whenever the DUT presents a sample.
module tb_pwm_demod;

  localparam int N    = 8;
  localparam int PW   = 13;
  localparam int HYST = 4;
  localparam int SW   = N + 1;
  localparam int CMAX = (1 << N) - 1;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct {
    logic [SW-1:0] sample;
    bit            pv;
    int            period;
    bit            silent;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          fs_clk;
  logic          pwm_pos;
  logic          pwm_neg;
  logic [SW-1:0] sample_o;
  logic          sample_valid;
  logic [PW-1:0] period_o;
  logic          period_valid;
  logic          silent_o;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  // Reference model state
  int acc_p, acc_n;
  bit primed;
  int zone;
  int since;
  bit have_ref_m;
  bit silent_m;

  pwm_demod #(.N(N), .PW(PW), .HYST(HYST)) dut (
    .clk(clk), .reset(reset), .fs_clk(fs_clk), .pwm_pos(pwm_pos), .pwm_neg(pwm_neg),
    .sample_o(sample_o), .sample_valid(sample_valid), .period_o(period_o),
    .period_valid(period_valid), .silent_o(silent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    acc_p = 0; acc_n = 0; primed = 0;
    zone = 0; since = 0; have_ref_m = 0; silent_m = 1;
  endtask

  // Sign-with-hysteresis view of the tone; a rising crossing is a move from
  // the negative zone into the positive zone
  task automatic model_sample(input int s);
    exp_t e;
    bit   rising;
    since++;
    rising = (zone == -1) && (s >= HYST);
    if (s >= HYST)       zone = 1;
    else if (s <= -HYST) zone = -1;
    e.pv = 0;
    e.period = 0;
    if (rising) begin
      e.pv = have_ref_m;
      e.period = since;
      have_ref_m = 1;
      silent_m = 0;
      since = 0;
    end else if (since == PMAX) begin
      have_ref_m = 0;
      silent_m = 1;
      zone = 0;
    end
    e.sample = s[SW-1:0];
    e.silent = silent_m;
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input bit f, input bit p, input bit n);
    @(posedge clk);
    #1;
    fs_clk = f; pwm_pos = p; pwm_neg = n;
    if (f) begin
      if (primed) model_sample(sat(acc_p) - sat(acc_n));
      primed = 1;
      acc_p = int'(p); acc_n = int'(n);
    end else begin
      acc_p += int'(p); acc_n += int'(n);
    end
  endtask

  task automatic frame(input int len, input int ps, input int ph, input int ns, input int nh);
    for (int c = 0; c < len; c++)
      drive_cycle(c == 0, (c >= ps) && (c < ps + ph), (c >= ns) && (c < ns + nh));
  endtask

  task automatic level(input int len, input int v);
    if (v >= 0) frame(len, 0, v, 0, 0);
    else        frame(len, 0, 0, 0, -v);
  endtask

  task automatic tone(input int len, input int reps);
    repeat (reps) begin
      repeat (5) level(len, 20);
      repeat (5) level(len, -20);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sample"}, sample_o, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_period"}, period_o, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_silent"}, silent_o, 1);
  endtask

  // Monitor: sample checked when presented, period/silence one cycle later
  initial begin
    exp_t cur;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("period_valid", period_valid, cur.pv);
          if (cur.pv) chk("period", period_o, cur.period);
          chk("silent", silent_o, cur.silent);
          pend = 0;
        end else begin
          chk("idle_period_valid", period_valid, 0);
        end
        if (sample_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_sample", sample_valid, 0);
          end else begin
            cur = sb.pop_front();
            chk("sample", sample_o, cur.sample);
            pend = 1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len, ph, ps, nh, ns;
    n_checks = 0; n_pass = 0;
    model_reset();
    reset = 1'b0; fs_clk = 1'b0; pwm_pos = 1'b0; pwm_neg = 1'b0;
    #23;
    check_reset_outputs("por");
    @(posedge clk); #1 reset = 1'b1;

    repeat (3) frame(125, 0, 40, 0, 0);
    repeat (2) frame(125, 0, 30, 20, 70);
    frame(300, 0, 300, 0, 0);
    frame(300, 0, 0, 0, 300);
    frame(300, 0, 300, 0, 300);
    frame(1, 0, 1, 0, 0);
    frame(1, 0, 0, 0, 1);
    frame(1, 0, 0, 0, 0);
    frame(1, 0, 1, 0, 1);

    tone(30, 4);
    repeat (10) begin level(8, 3); level(8, -3); end
    repeat (4) begin level(8, 4); level(8, -4); end

    repeat (PMAX + 10) frame(1, 0, 0, 0, 0);
    tone(25, 3);

    // Reset dropped in the middle of a running tone
    repeat (3) level(30, 20);
    drive_cycle(1, 1, 0);
    repeat (10) drive_cycle(0, 1, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("mid");
    sb.delete();
    model_reset();
    fs_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tone(25, 3);

    repeat (300) begin
      len = int'($urandom_range(1, 40));
      if ($urandom_range(0, 15) == 0) len = 300;
      ph = int'($urandom_range(0, len));
      ps = int'($urandom_range(0, len - ph));
      nh = int'($urandom_range(0, len));
      ns = int'($urandom_range(0, len - nh));
      frame(len, ps, ph, ns, nh);
    end

    drive_cycle(1, 0, 0);
    repeat (4) drive_cycle(0, 0, 0);
    chk("queue_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Receive-side counterpart to the melody PWM output path. Takes the differential PWM pair (`pwm_pos`, `pwm_neg`) and measures the high time of each line per sample frame. Frames are delimited by the same `fs_clk` strobe the DAC uses. The block rebuilds the signed sine sample, then finds rising zero crossings to report the tone period in samples, for loopback self-test and pitch checking of the generated melody.

## Interface
- `N`, 8: DAC resolution; per-line high count saturates at 2^N-1.
- `PW`, 13: width of the period counter and of `period_o`.
- `HYST`, 4: zero-crossing hysteresis threshold, in sample LSBs (unsigned, < 2^N).

- `clk`  in  1: system clock (1 MHz).
- `reset`  in  1: asynchronous, active-low reset.
- `fs_clk`  in  1: one-cycle frame strobe (every 125 `clk` at 8 kHz).
- `pwm_pos`  in  1: positive-half PWM line.
- `pwm_neg`  in  1: negative-half PWM line.
- `sample_o`  out  N+1: signed reconstructed sample (two's complement).
- `sample_valid`  out  1: one-cycle pulse; `sample_o` is new.
- `period_o`  out  PW: samples between the last two rising crossings.
- `period_valid`  out  1: one-cycle pulse; `period_o` is new.
- `silent_o`  out  1: no rising crossing within 2^PW-1 samples.

## Operation
- Frame definition: from a `fs_clk` cycle (inclusive) to the next `fs_clk` cycle (exclusive).
- Counters `pos_cnt` and `neg_cnt` (N bits) add 1 on each cycle their line is high. Both lines high in the same cycle: both counters increment. Each counter saturates at 2^N-1 and never wraps.
- On a `fs_clk` cycle:
  - `sample_o` <= zero-extended `pos_cnt` minus zero-extended `neg_cnt`, computed in N+1 bits.
  - Each counter reloads to the current cycle's line value (0 or 1).
- Priming: the first `fs_clk` after reset only starts a frame. It produces no `sample_valid` and leaves `sample_o` unchanged. Every later `fs_clk` produces a sample.
- Crossing FSM, advanced only on valid samples:
  - IDLE: sample <= -HYST -> BELOW. sample >= +HYST -> ABOVE.
  - ABOVE: sample <= -HYST -> BELOW. Otherwise stay.
  - BELOW: sample >= +HYST -> ABOVE, and that sample is a rising crossing. Otherwise stay.
  - Samples strictly inside (-HYST, +HYST) never change state.
- Period counter `pcnt` (PW bits):
  - On every valid sample: `pcnt` <= `pcnt`+1, saturating at 2^PW-1.
  - On a rising-crossing sample: `pcnt` <= 0. The reported period counts valid samples from the previous crossing sample (exclusive) to the current one (inclusive), i.e. `pcnt`+1 before the clear.
  - If `have_ref` is set at the crossing: `period_o` <= that count and `period_valid` pulses.
  - Every crossing sets `have_ref` and clears `silent_o`. The first crossing after reset or after silence gives no period.
- Silence: if `pcnt` reaches 2^PW-1, clear `have_ref`, set `silent_o` and move the FSM to IDLE.
- Reset (async, any time, including mid-frame) clears all of the following:
  - `sample_o`, `period_o`, `sample_valid`, `period_valid` = 0.
  - `silent_o` = 1.
  - Both counters, `pcnt` and `have_ref` = 0; priming flag cleared.
  - FSM = IDLE.

## Timing
- `sample_valid` pulses in the cycle after the `fs_clk` cycle. `sample_o` is registered and holds until the next sample.
- The crossing decision uses registered `sample_o`. `period_valid` and `silent_o` changes appear 2 cycles after the `fs_clk` cycle that closed the frame.
- Back-to-back `fs_clk` in consecutive cycles is legal. The 1-cycle frame gives a sample from the reload value only.
- `fs_clk` held for several cycles counts as one strobe per cycle. Driving it that way is not allowed; the block does not detect it.
- `pwm_pos` and `pwm_neg` are synchronous to `clk`; no synchronizer is needed.
- Throughput: one sample per frame, no stalls, no backpressure.

## Test plan
- `fs_clk` every 125 cycles, `pwm_pos` high 40 cycles per frame, `pwm_neg` low. Expect: from the 2nd strobe on, `sample_o`=+40 with `sample_valid` at strobe+1; nothing on the first strobe.
- Per frame, `pwm_pos` high 30 cycles and `pwm_neg` high 70 cycles, with 10 cycles overlapping. Expect `sample_o`=-40 (9'h1D8).
- N=4, `pwm_pos` held high for a whole 125-cycle frame. Expect `sample_o`=+15 (saturated, no wrap).
- Frames alternating 5 at +20 and 5 at -20. Expect: first crossing gives no `period_valid`; every later crossing gives `period_o`=10; `silent_o` falls after the first crossing.
- Samples oscillating between +3 and -3 with HYST=4. Expect no crossing ever; with PW=4, `silent_o` stays 1 after 15 samples.
- Drop `reset` low mid-frame during a running tone, then release it. Expect all outputs at their reset values at once, and the first strobe after release discarded.
